// File: rtl/elastic_pkg.sv
// Shared types for the elastic skid stage: state encoding and reset state.
package elastic_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } elastic_state_e;

   localparam elastic_state_e elastic_state_reset_lp = EMPTY;

endpackage

// File: rtl/elastic_en_reg.sv
// Enable register for the skid stage datapath; async clear only when datapath_reset_p=1.
module elastic_en_reg #(
   parameter int width_p          = 8,
   parameter bit datapath_reset_p = 1'b0
) (
   input  logic               clk_i,
   input  logic               reset_ni,
   input  logic               en_i,
   input  logic [width_p-1:0] d_i,
   output logic [width_p-1:0] q_o
);

   logic [width_p-1:0] data_q;

   if (datapath_reset_p) begin : g_rst
      always_ff @(posedge clk_i or negedge reset_ni) begin
         if (!reset_ni)  data_q <= '0;
         else if (en_i)  data_q <= d_i;
      end
   end else begin : g_norst
      // Data flops stay reset-free; reset is still a port so both variants share one interface.
      logic unused_reset;
      assign unused_reset = reset_ni;
      always_ff @(posedge clk_i) begin
         if (en_i) data_q <= d_i;
      end
   end

   assign q_o = data_q;

endmodule

// File: rtl/elastic_skid.sv
// Full-throughput valid/ready skid stage: main register drives data_o, skid absorbs
// the one extra word accepted while ready_o is still registered high.
module elastic_skid
   import elastic_pkg::*;
#(
   parameter int width_p          = 8,
   parameter bit datapath_reset_p = 1'b0
) (
   input  logic               clk_i,
   input  logic               reset_ni,
   input  logic               valid_i,
   output logic               ready_o,
   input  logic [width_p-1:0] data_i,
   output logic               valid_o,
   input  logic               ready_i,
   output logic [width_p-1:0] data_o
);

   elastic_state_e     state_q, state_d;
   logic               valid_q, ready_q;
   logic               in_fire, out_fire;
   logic               main_en, skid_en;
   logic [width_p-1:0] main_d, main_q, skid_q;

   assign in_fire  = valid_i & ready_q;
   assign out_fire = valid_q & ready_i;

   always_comb begin
      state_d = state_q;
      main_en = 1'b0;
      skid_en = 1'b0;
      main_d  = data_i;
      case (state_q)
         EMPTY: if (in_fire) begin
            state_d = BUSY;
            main_en = 1'b1;
         end
         BUSY: begin
            if (in_fire && out_fire) begin
               main_en = 1'b1;
            end else if (in_fire) begin
               state_d = FULL;
               skid_en = 1'b1;
            end else if (out_fire) begin
               state_d = EMPTY;
            end
         end
         FULL: if (out_fire) begin
            state_d = BUSY;
            main_en = 1'b1;
            main_d  = skid_q;
         end
         default: state_d = EMPTY;
      endcase
   end

   // Handshake outputs are flopped from next state so ready_i never reaches ready_o combinationally.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q <= elastic_state_reset_lp;
         valid_q <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         valid_q <= (state_d != EMPTY);
         ready_q <= (state_d != FULL);
      end
   end

   elastic_en_reg #(.width_p(width_p), .datapath_reset_p(datapath_reset_p)) u_main (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .en_i     (main_en),
      .d_i      (main_d),
      .q_o      (main_q)
   );

   elastic_en_reg #(.width_p(width_p), .datapath_reset_p(datapath_reset_p)) u_skid (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .en_i     (skid_en),
      .d_i      (data_i),
      .q_o      (skid_q)
   );

   assign valid_o = valid_q;
   assign ready_o = ready_q;
   assign data_o  = main_q;

endmodule

// File: tb/tb_elastic_skid.sv
// Directed and randomized-stall bench for elastic_skid with a queue scoreboard.
module tb_elastic_skid;

   logic       clk_i = 1'b0;
   logic       reset_ni;
   logic       valid_i, ready_i, ready_o, valid_o;
   logic [7:0] data_i, data_o;

   int errs   = 0;
   int checks = 0;

   always #5 clk_i = ~clk_i;

   elastic_skid #(.width_p(8), .datapath_reset_p(1'b1)) dut (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .valid_i  (valid_i),
      .ready_o  (ready_o),
      .data_i   (data_i),
      .valid_o  (valid_o),
      .ready_i  (ready_i),
      .data_o   (data_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      logic [7:0] q[$];
      logic       stall, hold_offer, in_f, out_f;
      logic [7:0] stall_data;

      // reset with a word offered
      reset_ni = 1'b0; valid_i = 1'b1; data_i = 8'hAA; ready_i = 1'b0;
      #1;
      chk("rst_valid_async", valid_o, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_valid", valid_o, 0);
         chk("rst_ready", ready_o, 0);
      end
      reset_ni = 1'b1;
      tick();
      chk("post_rst_ready", ready_o, 1);
      chk("post_rst_valid", valid_o, 0);
      chk("post_rst_data", data_o, 8'h00);
      valid_i = 1'b0;

      // continuous stream 1..10
      for (int i = 1; i <= 10; i++) begin
         valid_i = 1'b1; ready_i = 1'b1; data_i = 8'(i);
         tick();
         chk("stream_data", data_o, i);
         chk("stream_valid", valid_o, 1);
         chk("stream_ready", ready_o, 1);
      end
      valid_i = 1'b0;
      tick();
      chk("stream_drain_valid", valid_o, 0);

      // back-pressure into FULL
      valid_i = 1'b1; data_i = 8'h11; ready_i = 1'b0;
      tick();
      chk("bp_busy_data", data_o, 8'h11);
      chk("bp_busy_ready", ready_o, 1);
      data_i = 8'h22;
      tick();
      chk("bp_full_ready", ready_o, 0);
      chk("bp_full_valid", valid_o, 1);
      chk("bp_full_data", data_o, 8'h11);
      data_i = 8'h33;
      tick();
      chk("bp_ignore_ready", ready_o, 0);
      chk("bp_ignore_data", data_o, 8'h11);
      ready_i = 1'b1;
      #1;
      chk("bp_release_data", data_o, 8'h11);
      tick();
      chk("bp_second_data", data_o, 8'h22);
      chk("bp_second_ready", ready_o, 1);
      tick();
      chk("bp_third_data", data_o, 8'h33);
      chk("bp_third_valid", valid_o, 1);
      valid_i = 1'b0;
      tick();
      chk("bp_empty_valid", valid_o, 0);
      chk("bp_empty_ready", ready_o, 1);

      // asynchronous reset while FULL
      valid_i = 1'b1; data_i = 8'h44; ready_i = 1'b0;
      tick();
      data_i = 8'h55;
      tick();
      chk("ar_full_ready", ready_o, 0);
      valid_i = 1'b0;
      #2;
      reset_ni = 1'b0;
      #1;
      chk("ar_valid_async", valid_o, 0);
      chk("ar_ready_async", ready_o, 0);
      chk("ar_data_async", data_o, 8'h00);
      reset_ni = 1'b1;
      tick();
      chk("ar_post_ready", ready_o, 1);
      ready_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("ar_no_ghost", valid_o, 0);
      end

      // drain to empty from BUSY
      valid_i = 1'b1; data_i = 8'h66; ready_i = 1'b0;
      tick();
      chk("drain_busy_data", data_o, 8'h66);
      valid_i = 1'b0; ready_i = 1'b1;
      #1;
      chk("drain_xfer_valid", valid_o, 1);
      tick();
      chk("drain_valid", valid_o, 0);
      chk("drain_ready", ready_o, 1);

      // randomized valid/ready with occupancy + order scoreboard
      stall = 1'b0; hold_offer = 1'b0; stall_data = '0;
      for (int c = 0; c < 1000; c++) begin
         chk("rnd_valid", valid_o, (q.size() != 0));
         chk("rnd_ready", ready_o, (q.size() < 2));
         if (q.size() != 0) chk("rnd_data", data_o, q[0]);
         if (stall) chk("rnd_stable", data_o, stall_data);
         if (!hold_offer) begin
            valid_i = 1'($urandom_range(0, 1));
            data_i  = 8'($urandom);
         end
         ready_i = 1'($urandom_range(0, 1));
         in_f  = valid_i & ready_o;
         out_f = valid_o & ready_i;
         if (out_f) void'(q.pop_front());
         if (in_f) q.push_back(data_i);
         hold_offer = valid_i & ~in_f;
         stall      = valid_o & ~ready_i;
         stall_data = data_o;
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/elastic_skid.md
Name: elastic_skid

Overview:
- Full-throughput elastic pipeline stage with a valid/ready handshake on both sides.
- It sits directly downstream of the enable-driven datapath registers. It converts their flow into a back-pressurable stream: a main register plus one skid register.
- Both ready_o and valid_o come straight from flops, so no combinational path runs from ready_i to ready_o.
- Sustains 1 transfer/cycle with zero bubbles under continuous flow.

Parameters:
- width_p, 8, data bus width in bits (must be >= 1)
- datapath_reset_p, 0, 1: reset clears the data registers to zero; 0: the data registers are not reset

Ports:
- clk_i  input  1  clock; all state updates on the rising edge
- reset_ni  input  1  asynchronous, active-low reset
- valid_i  input  1  upstream has a word on data_i
- ready_o  output  1  stage can accept a word this cycle
- data_i  input  width_p  upstream data
- valid_o  output  1  data_o holds a valid word
- ready_i  input  1  downstream accepts data_o this cycle
- data_o  output  width_p  downstream data, driven from the main register

Behaviour:
- Clock and reset (already decided): one clock, clk_i; reset_ni is asynchronous and active-low.
- Transfer definitions:
  - in_fire = valid_i & ready_o
  - out_fire = valid_o & ready_i
- Reset:
  - While reset_ni=0: state=EMPTY, valid_o=0, ready_o=0.
  - First rising edge after deassertion: ready_o=1.
  - Data registers are cleared to 0 only when datapath_reset_p=1; otherwise they hold X/unknown until first written.
- States (2-bit encoded) and their outputs:
  - EMPTY: valid_o=0, ready_o=1
  - BUSY: main full; valid_o=1, ready_o=1
  - FULL: main and skid full; valid_o=1, ready_o=0
- Transitions (registered):
  - EMPTY & in_fire -> BUSY; main <= data_i.
  - BUSY & in_fire & out_fire -> BUSY; main <= data_i.
  - BUSY & in_fire & !out_fire -> FULL; skid <= data_i.
  - BUSY & !in_fire & out_fire -> EMPTY.
  - FULL & out_fire -> BUSY; main <= skid.
  - All other cases hold the current state.
- Latency: a word accepted at edge N appears on data_o with valid_o=1 after edge N (one cycle) when the stage was EMPTY or draining.
- Ordering: strict FIFO; no word is dropped or duplicated.
- Stability: while valid_o=1 and ready_i=0, data_o and valid_o hold.
- valid_i while ready_o=0 is ignored; data_i is not sampled. Upstream must hold its word until it is accepted.
- FULL: ready_o deasserts the cycle after the skid fills, which is why the skid register is needed.
- ready_i toggling while EMPTY has no effect.
- Reset asserted mid-operation: clears immediately (asynchronous). All buffered words are discarded; valid_o drops without waiting for a clock edge.
- Invalid state encoding (4th code) recovers to EMPTY on the next edge.
- No arithmetic; widths pass through unchanged.

Decomposition:
- Shared package elastic_pkg:
  - typedef enum logic [1:0] elastic_state_e {EMPTY, BUSY, FULL}
  - localparam elastic_state_reset_lp = EMPTY
- Natural sub-module: elastic_en_reg. It is a width_p enable register with async active-low reset gated by datapath_reset_p. Instantiate it twice, as main and skid.
- State machine and muxing stay in the top module.

Test Plan:
- Reset: hold reset_ni=0 for 3 cycles with valid_i=1, data_i=8'hAA -> valid_o=0, ready_o=0 throughout. One edge after release: ready_o=1, valid_o=0. With datapath_reset_p=1, data_o=8'h00.
- Continuous stream: valid_i=1, ready_i=1, data_i=1,2,...,10 on consecutive cycles -> data_o=1..10 on consecutive cycles, one cycle delayed; ready_o stays 1; no bubbles.
- Back-pressure: send 8'h11, then 8'h22 with ready_i=0 -> state FULL, ready_o=0, data_o=8'h11 stable; 8'h33 offered is ignored. Raise ready_i -> data_o=8'h11, then 8'h22, then 8'h33 after re-offer.
- Random stall: randomized valid_i and ready_i at 50% for 1000 cycles -> scoreboard matches in order; data_o never changes while valid_o=1 and ready_i=0.
- Async reset in FULL: fill with 8'h44 and 8'h55, pulse reset_ni low mid-cycle -> valid_o=0 before the next clock edge. After release the stage is EMPTY, and 8'h44/8'h55 never appear.
- Drain to empty: from BUSY with 8'h66, valid_i=0, ready_i=1 -> 8'h66 transfers, next cycle valid_o=0, ready_o=1.
